// File: rtl/boot_load_pkg.sv
// Shared state encoding and default sizing for the instruction-memory boot loader.
package boot_load_pkg;

  localparam int unsigned DEF_ADDR_W   = 11;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_RST_HOLD = 4;
  // Hold counter spans 0..RST_HOLD with RST_HOLD up to 255.
  localparam int unsigned HOLD_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/boot_load_ctrl.sv
// Loads a program into instruction memory over valid/ready, then clocks the CPU
// through a programmable reset window and releases it.
module boot_load_ctrl
  import boot_load_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RST_HOLD = DEF_RST_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic [DATA_W-1:0] w_instruction,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic              cpu_en,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(RST_HOLD);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              handshake;

  assign handshake = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      hold_cnt      <= '0;
      word_ready    <= 1'b0;
      w_instruction <= '0;
      w_enable      <= 1'b0;
      w_adrs        <= '0;
      cpu_en        <= 1'b0;
      cpu_resetn    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      word_count    <= '0;
    end else begin
      // Write strobe is a one-cycle echo of each accepted word.
      w_enable <= 1'b0;

      case (state)
        IDLE, ERR: begin
          if (start) begin
            state      <= LOAD;
            addr       <= '0;
            word_count <= '0;
            word_ready <= 1'b1;
            busy       <= 1'b1;
            error      <= 1'b0;
          end
        end

        LOAD: begin
          if (handshake) begin
            w_enable      <= 1'b1;
            w_adrs        <= addr;
            w_instruction <= word_data;
            addr          <= addr + ADDR_W'(1);
            word_count    <= word_count + CNT_W'(1);
            // A last flag on the final slot is a legal full-memory program.
            if (word_last) begin
              state      <= HOLD;
              word_ready <= 1'b0;
              hold_cnt   <= '0;
            end else if (addr == ADDR_MAX) begin
              state      <= ERR;
              word_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end
          end
        end

        // Count 0 drains the final write; the CPU port is taken only afterwards.
        HOLD: begin
          if (hold_cnt == HOLD_END) begin
            state      <= RUN;
            cpu_resetn <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            cpu_en   <= 1'b1;
          end
        end

        RUN: begin
          if (stop) begin
            state      <= IDLE;
            cpu_en     <= 1'b0;
            cpu_resetn <= 1'b0;
            done       <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/boot_load_ctrl.md
# boot_load_ctrl

Sequencer that owns the instruction-memory write port before the CPU runs. It accepts a stream of 32-bit program words over a valid/ready handshake and writes them to consecutive memory addresses from 0. It then enables the gated CPU clock, holds the CPU in reset for a programmable number of cycles, and releases it. Its `w_instruction`/`w_enable`/`w_adrs`/`cpu_en` outputs drive the top-level inputs of the same names, which mux the memory write port between loader and CPU.

## Interface
- `ADDR_W`, 11: memory word-address width; load capacity is 2^ADDR_W words.
- `DATA_W`, 32: instruction word width.
- `RST_HOLD`, 4: cycles the CPU is clocked with `cpu_resetn`=0 before release; legal range 1..255.

Ports:
- `clk`  in  1  single clock; also clocks the memory.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load from IDLE or ERR.
- `stop`  in  1  single-cycle pulse; in RUN, halts the CPU and returns to IDLE.
- `word_valid`  in  1  a program word is presented.
- `word_data`  in  DATA_W  program word.
- `word_last`  in  1  qualifies the final word of the program.
- `word_ready`  out  1  loader accepts a word this cycle.
- `w_instruction`  out  DATA_W  memory write data.
- `w_enable`  out  1  memory write strobe.
- `w_adrs`  out  ADDR_W  memory write address.
- `cpu_en`  out  1  CPU clock enable / memory-port select.
- `cpu_resetn`  out  1  active-low reset to the CPU.
- `busy`  out  1  high in LOAD or HOLD.
- `done`  out  1  high in RUN.
- `error`  out  1  high in ERR.
- `word_count`  out  ADDR_W+1  number of words accepted in the current/last load.

## Operation
- All outputs are registered. Reset values: `word_ready`, `w_enable`, `cpu_en`, `busy`, `done` and `error` are 0. `cpu_resetn` is 0. `w_adrs`, `w_instruction` and `word_count` are 0. State is IDLE.
- **IDLE**: CPU stopped and in reset.
  - `start` → LOAD. Clears the address counter and `word_count`.
- **LOAD**: `word_ready`=1.
  - Handshake = `word_valid`&&`word_ready`.
  - Each handshake increments `word_count`, and the address counter by 1.
  - Handshake with `word_last` → HOLD.
  - Handshake at address 2^ADDR_W−1 without `word_last` → ERR. That word is still written.
- **HOLD**: `word_ready`=0.
  - Counter runs RST_HOLD+1 cycles. Cycle 0 is a drain cycle with `cpu_en`=0.
  - Cycles 1..RST_HOLD: `cpu_en`=1, `cpu_resetn`=0.
  - Then → RUN.
- **RUN**: `cpu_en`=1, `cpu_resetn`=1, `done`=1.
  - `stop` → IDLE: `cpu_en`=0, `cpu_resetn`=0, the next cycle.
  - `start` is ignored.
- **ERR**: `error`=1, CPU stopped.
  - `start` → LOAD (fresh load).
  - `stop` is ignored.
- `start` is ignored in LOAD, HOLD and RUN. `stop` is ignored outside RUN.
- Simultaneous `start` and `stop`:
  - `stop` wins in RUN.
  - `start` wins in IDLE/ERR.
- Invariant: `w_enable`=1 implies `cpu_en`=0. Write-port ownership never overlaps.
- `reset` mid-load or mid-run: next cycle all outputs take their reset values and the state is IDLE. Partial memory contents are left as-is.

## Timing
- Write latency is 1 cycle. A handshake in cycle T produces `w_enable`=1 in T+1, with `w_adrs` = that word's address and `w_instruction` = its data.
- Back-to-back handshakes give one write per cycle. Gaps in `word_valid` give `w_enable`=0 in the matching cycles.
- Last handshake at T:
  - Last write in T+1 (HOLD cycle 0).
  - `cpu_en` rises at T+2.
  - `cpu_resetn` rises at T+2+RST_HOLD.
  - `done` rises at T+2+RST_HOLD.
- `start` in IDLE at cycle S gives `word_ready`=1 at S+1.
- `word_count` updates in the cycle after each handshake and holds its value through HOLD and RUN.

## Structure
- Shared package `boot_load_pkg`:
  - state enum (IDLE, LOAD, HOLD, RUN, ERR);
  - default `ADDR_W`/`DATA_W`/`RST_HOLD` constants.
- No sub-module. The address counter and hold counter are inline in one FSM module.

## Test plan
- Load 3 words 0x11,0x22,0x33 (last on 3rd), `word_valid` held high → writes at addr 0,1,2 in consecutive cycles. `cpu_en` rises 2 cycles after the last handshake. `cpu_resetn`/`done` rise 4 cycles later. `word_count`=3.
- Same load with `word_valid` low for 2 cycles between words → `w_enable` has matching gaps, addresses still 0,1,2, and `w_enable`/`cpu_en` are never high together.
- `ADDR_W`=3, 8 words, none with `word_last` → 8 writes at addrs 0..7, then `error`=1 and `cpu_en`=0. A following `start` restarts at addr 0.
- `ADDR_W`=3, 8 words with `word_last` on the 8th → no error, RUN reached.
- `reset` asserted after 2 of 5 words → next cycle IDLE with all outputs at reset values. New `start` plus 1 word writes addr 0.
- In RUN, pulse `stop` → `cpu_en`=0 and `cpu_resetn`=0 next cycle. `start` pulsed during LOAD is ignored: the address is not reset.
